// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes, functs,
// FSM states, ALU operation encoding and funct decode helpers.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_SLT = 6'd42;
    localparam logic [5:0] FN_SLL = 6'd0;
    localparam logic [5:0] FN_SRL = 6'd2;
    localparam logic [5:0] FN_JR  = 6'd8;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    // R-type functs that produce a register result (jr excluded)
    function automatic logic is_alu_funct(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT) || (funct == FN_SLL) ||
               (funct == FN_SRL);
    endfunction

    function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU.
// Ports: in0/in1 operands, shamt shift amount (shifts apply to in1),
//        op operation select, result, zero (result == 0).
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [4:0]  shamt,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (op)
            ALU_ADD: result = in0 + in1;
            ALU_SUB: result = in0 - in1;
            ALU_AND: result = in0 & in1;
            ALU_OR:  result = in0 | in1;
            ALU_SLT: result = ($signed(in0) < $signed(in1)) ? 32'd1 : 32'd0;
            ALU_SLL: result = in1 << shamt;
            ALU_SRL: result = in1 >> shamt;
            default: result = 32'd0;
        endcase
        zero = (result == 32'd0);
    end

endmodule

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS-subset core (FETCH/DECODE/EXEC/MEM/WB) with handshaked
// instruction and data memories.
// Ports: clk, rst_n (synchronous, active-low);
//        i_req/i_addr/i_ready/i_data instruction fetch handshake;
//        d_req/d_we/d_addr/d_wdata/d_ready/d_rdata data access handshake;
//        retire pulses the cycle after an instruction completes;
//        illegal is sticky on an unsupported opcode/funct.
module multicycle_mips
    import mips_pkg::*;
#(
    parameter int unsigned DMEM_AW       = 7,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned NUM_REGS_LOG2 = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               i_req,
    output logic [31:0]        i_addr,
    input  logic               i_ready,
    input  logic [31:0]        i_data,
    output logic               d_req,
    output logic               d_we,
    output logic [DMEM_AW-1:0] d_addr,
    output logic [31:0]        d_wdata,
    input  logic               d_ready,
    input  logic [31:0]        d_rdata,
    output logic               retire,
    output logic               illegal
);

    localparam int unsigned RW       = NUM_REGS_LOG2;
    localparam int unsigned NUM_REGS = 32'd1 << NUM_REGS_LOG2;

    state_e        state, state_d;
    logic [31:0]   pc, ir, a_reg, b_reg, imm, alu_out, mdr;
    logic [31:0]   regs [NUM_REGS];

    logic [5:0]    opcode, funct;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx;
    logic [31:0]   rs_val, rt_val;

    alu_op_e       alu_op;
    logic [31:0]   alu_in1, alu_result;
    logic          alu_zero;

    logic          pc_we, ir_we, ab_we, alu_we, mdr_we, rf_we;
    logic          retire_d, illegal_set;
    logic [31:0]   pc_d, rf_wdata;
    logic [RW-1:0] rf_waddr;

    assign opcode  = ir[31:26];
    assign funct   = ir[5:0];
    assign rs_idx  = RW'(ir[25:21]);
    assign rt_idx  = RW'(ir[20:16]);
    assign rd_idx  = RW'(ir[15:11]);
    assign rs_val  = (rs_idx == '0) ? 32'd0 : regs[rs_idx];
    assign rt_val  = (rt_idx == '0) ? 32'd0 : regs[rt_idx];

    assign i_addr  = pc;
    assign d_addr  = alu_out[DMEM_AW-1:0];
    assign d_wdata = b_reg;

    // Operand/op select: R-type uses funct, branches compare by subtraction
    always_comb begin
        alu_op  = ALU_ADD;
        alu_in1 = imm;
        if (opcode == OP_RTYPE) begin
            alu_op  = funct_to_alu(funct);
            alu_in1 = b_reg;
        end else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) begin
            alu_op  = ALU_SUB;
            alu_in1 = b_reg;
        end
    end

    mips_alu u_alu (
        .in0    (a_reg),
        .in1    (alu_in1),
        .shamt  (ir[10:6]),
        .op     (alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_d;
    end

    // Next state and datapath control
    always_comb begin
        state_d     = state;
        pc_we       = 1'b0;
        pc_d        = pc;
        ir_we       = 1'b0;
        ab_we       = 1'b0;
        alu_we      = 1'b0;
        mdr_we      = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = alu_out;
        retire_d    = 1'b0;
        illegal_set = 1'b0;
        case (state)
            FETCH: begin
                // i_req is low in the cycle right after reset; only a real request completes
                if (i_req && i_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_d    = pc + 32'd4;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ab_we   = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                alu_we   = 1'b1;
                state_d  = FETCH;
                retire_d = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_we = 1'b1;
                            pc_d  = a_reg;
                        end else if (is_alu_funct(funct)) begin
                            state_d  = WB;
                            retire_d = 1'b0;
                        end else begin
                            illegal_set = 1'b1;
                        end
                    end
                    OP_J, OP_JAL: begin
                        pc_we = 1'b1;
                        pc_d  = {pc[31:28], ir[25:0], 2'b00};
                        if (opcode == OP_JAL) begin
                            rf_we    = 1'b1;
                            rf_waddr = RW'(31);
                            rf_wdata = pc;
                        end
                    end
                    OP_BEQ, OP_BNE: begin
                        if (alu_zero == (opcode == OP_BEQ)) begin
                            pc_we = 1'b1;
                            pc_d  = pc + {imm[29:0], 2'b00};
                        end
                    end
                    OP_ADDI: begin
                        state_d  = WB;
                        retire_d = 1'b0;
                    end
                    OP_LW, OP_SW: begin
                        state_d  = MEM;
                        retire_d = 1'b0;
                    end
                    default: illegal_set = 1'b1;
                endcase
            end
            MEM: begin
                if (d_req && d_ready) begin
                    if (opcode == OP_SW) begin
                        state_d  = FETCH;
                        retire_d = 1'b1;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we    = 1'b1;
                rf_waddr = (opcode == OP_RTYPE) ? rd_idx : rt_idx;
                rf_wdata = (opcode == OP_LW) ? mdr : alu_out;
                state_d  = FETCH;
                retire_d = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Registered handshake and status outputs, derived from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_req   <= 1'b0;
            d_req   <= 1'b0;
            d_we    <= 1'b0;
            retire  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            i_req   <= (state_d == FETCH);
            d_req   <= (state_d == MEM);
            d_we    <= (state_d == MEM) && (opcode == OP_SW);
            retire  <= retire_d;
            illegal <= illegal | illegal_set;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            ir      <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            imm     <= 32'd0;
            alu_out <= 32'd0;
            mdr     <= 32'd0;
        end else begin
            if (pc_we)  pc      <= pc_d;
            if (ir_we)  ir      <= i_data;
            if (ab_we) begin
                a_reg <= rs_val;
                b_reg <= rt_val;
                imm   <= {{16{ir[15]}}, ir[15:0]};
            end
            if (alu_we) alu_out <= alu_result;
            if (mdr_we) mdr     <= d_rdata;
        end
    end

    // Register file; register 0 is never written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[RW'(i)] <= 32'd0;
        end else if (rf_we && (rf_waddr != '0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_mips.sv
// Bench for multicycle_mips: directed program plus randomized instruction
// stream, checked against an instruction-level reference model.
module tb_multicycle_mips;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_ready, d_req, d_we, d_ready, retire, illegal;
    logic [31:0] i_addr, i_data, d_wdata, d_rdata;
    logic [6:0]  d_addr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_r [32];
    logic [31:0] m_mem [128];
    logic [31:0] m_pc;
    logic        m_ill;
    int          exp_kind;   // 0 none, 1 load, 2 store
    int          exp_lat;
    logic [6:0]  exp_daddr;
    logic [31:0] exp_wdata;

    multicycle_mips dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_ready (i_ready),
        .i_data  (i_data),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ready (d_ready),
        .d_rdata (d_rdata),
        .retire  (retire),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input int target);
        return {6'(op), 26'(target)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_r[i] = 32'd0;
        m_pc  = 32'h0000_0000;
        m_ill = 1'b0;
    endtask

    task automatic wreg(input logic [4:0] idx, input logic [31:0] v);
        if (idx != 5'd0) m_r[idx] = v;
    endtask

    // ISA-level execution of one instruction; sets the expected bus activity
    task automatic model_step(input logic [31:0] ins);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh;
        logic [31:0] va, vb, simm, npc, sum;
        op   = ins[31:26];
        rs   = ins[25:21];
        rt   = ins[20:16];
        rd   = ins[15:11];
        sh   = ins[10:6];
        fn   = ins[5:0];
        simm = {{16{ins[15]}}, ins[15:0]};
        va   = m_r[rs];
        vb   = m_r[rt];
        npc  = m_pc + 32'd4;
        sum  = va + simm;
        exp_kind  = 0;
        exp_lat   = 3;
        exp_daddr = sum[6:0];
        exp_wdata = vb;
        case (op)
            6'd0: begin
                exp_lat = 4;
                case (fn)
                    6'd32: wreg(rd, va + vb);
                    6'd34: wreg(rd, va - vb);
                    6'd36: wreg(rd, va & vb);
                    6'd37: wreg(rd, va | vb);
                    6'd42: wreg(rd, ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0);
                    6'd0:  wreg(rd, vb << sh);
                    6'd2:  wreg(rd, vb >> sh);
                    6'd8:  begin npc = va; exp_lat = 3; end
                    default: begin m_ill = 1'b1; exp_lat = 3; end
                endcase
            end
            6'd2: npc = {npc[31:28], ins[25:0], 2'b00};
            6'd3: begin
                wreg(5'd31, npc);
                npc = {npc[31:28], ins[25:0], 2'b00};
            end
            6'd4: if (va == vb) npc = npc + (simm << 2);
            6'd5: if (va != vb) npc = npc + (simm << 2);
            6'd8: begin wreg(rt, sum); exp_lat = 4; end
            6'd35: begin exp_kind = 1; exp_lat = 5; wreg(rt, m_mem[sum[6:0]]); end
            6'd43: begin exp_kind = 2; exp_lat = 4; m_mem[sum[6:0]] = vb; end
            default: m_ill = 1'b1;
        endcase
        m_pc = npc;
    endtask

    // Run one instruction end to end with the given fetch / data wait states
    task automatic exec_one(input logic [31:0] ins, input int iw, input int dw);
        int n;
        bit d_done;
        n = 0;
        while (!i_req && n < 20) begin @(negedge clk); n++; end
        chk("fetch_req", i_req, 1);
        chk("fetch_addr", i_addr, m_pc);
        n = 0;
        for (int k = 0; k < iw; k++) begin
            i_ready = 1'b0;
            @(negedge clk); n++;
            chk("fetch_hold_req", i_req, 1);
            chk("fetch_hold_addr", i_addr, m_pc);
        end
        i_ready = 1'b1;
        i_data  = ins;
        @(negedge clk); n++;
        i_ready = 1'b0;
        i_data  = $urandom;
        chk("retire_pulse", retire, 0);
        model_step(ins);
        d_done = 1'b0;
        while (!retire && n < 60) begin
            chk("req_excl", i_req & d_req, 0);
            if (d_req && !d_done) begin
                chk("d_req_expected", d_req, exp_kind != 0);
                chk("d_we", d_we, exp_kind == 2);
                chk("d_addr", d_addr, exp_daddr);
                if (exp_kind == 2) chk("d_wdata", d_wdata, exp_wdata);
                for (int k = 0; k < dw; k++) begin
                    d_ready = 1'b0;
                    @(negedge clk); n++;
                    chk("d_hold", d_req, 1);
                end
                d_ready = 1'b1;
                d_rdata = m_mem[exp_daddr];
                @(negedge clk); n++;
                d_ready = 1'b0;
                d_rdata = $urandom;
                d_done  = 1'b1;
            end else begin
                @(negedge clk); n++;
            end
        end
        chk("retire", retire, 1);
        chk("mem_access_seen", d_done, exp_kind != 0);
        chk("latency", n, exp_lat + iw + ((exp_kind != 0) ? dw : 0));
        chk("illegal", illegal, m_ill);
    endtask

    function automatic int rreg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 31 : r;
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        int fl [7];
        fl = '{32, 34, 36, 37, 42, 0, 2};
        k  = $urandom_range(0, 24);
        case (k)
            7, 8:    return enc_i(8, rreg(), rreg(), int'($urandom_range(0, 65535)));
            9, 10:   return enc_i(35, rreg(), rreg(), int'($urandom_range(0, 127)));
            11, 12:  return enc_i(43, rreg(), rreg(), int'($urandom_range(0, 127)));
            13:      return enc_i(4, rreg(), rreg(), int'($urandom_range(0, 15)) - 8);
            14:      return enc_i(5, rreg(), rreg(), int'($urandom_range(0, 15)) - 8);
            15:      return enc_j(2, int'($urandom_range(0, 4095)));
            16:      return enc_j(3, int'($urandom_range(0, 4095)));
            17:      return enc_r(rreg(), 0, 0, 0, 8);
            18:      return enc_i(63, rreg(), rreg(), 0);
            19:      return enc_r(rreg(), rreg(), rreg(), 0, 3);
            default: return enc_r(rreg(), rreg(), rreg(), int'($urandom_range(0, 31)),
                                  fl[$urandom_range(0, 6)]);
        endcase
    endfunction

    initial begin
        int n;
        rst_n   = 1'b0;
        i_ready = 1'b0;
        i_data  = 32'd0;
        d_ready = 1'b0;
        d_rdata = 32'd0;
        for (int i = 0; i < 128; i++) m_mem[i] = $urandom;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_i_req", i_req, 0);
        chk("rst_d_req", d_req, 0);
        chk("rst_d_we", d_we, 0);
        chk("rst_retire", retire, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_pc", i_addr, 32'h0000_0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_i_req", i_req, 1);

        // Directed program
        exec_one(enc_i(8, 0, 1, 5), 0, 0);         // addi $1,$0,5
        exec_one(enc_i(8, 1, 2, -3), 0, 0);        // addi $2,$1,-3
        exec_one(enc_r(1, 2, 3, 0, 32), 0, 0);     // add  $3,$1,$2
        exec_one(enc_i(43, 0, 3, 4), 0, 2);        // sw   $3,4($0)
        chk("sw_data_7", m_mem[4], 32'd7);
        exec_one(enc_i(35, 0, 4, 4), 0, 2);        // lw   $4,4($0)
        exec_one(enc_i(4, 1, 1, 2), 1, 0);         // beq taken -> 0x20
        exec_one(enc_j(3, 32'h40), 0, 0);          // jal 0x40 -> 0x100
        exec_one(enc_i(43, 0, 31, 8), 1, 0);       // sw $31,8($0) -> 0x24
        exec_one(enc_i(5, 1, 1, 2), 0, 0);         // bne not taken
        exec_one(enc_i(8, 0, 0, 9), 0, 0);         // addi $0,$0,9
        exec_one(enc_i(43, 0, 0, 12), 0, 1);       // sw $0 -> 0
        exec_one(enc_i(43, 0, 4, 16), 2, 0);       // sw $4 -> 7
        exec_one(32'hFC00_0000, 0, 0);             // opcode 0x3F
        exec_one(enc_r(1, 2, 5, 0, 34), 0, 0);     // sub $5,$1,$2
        exec_one(enc_r(2, 1, 6, 0, 42), 0, 0);     // slt $6,$2,$1
        exec_one(enc_r(0, 1, 7, 3, 0), 0, 0);      // sll $7,$1,3
        exec_one(enc_i(43, 0, 7, 20), 0, 0);       // sw $7 -> 40
        exec_one(enc_r(31, 0, 0, 0, 8), 0, 0);     // jr $31 -> 0x24
        exec_one(enc_i(43, 0, 6, 24), 0, 0);       // sw $6 -> 1

        // Reset while a load waits on d_ready
        n = 0;
        while (!i_req && n < 20) begin @(negedge clk); n++; end
        chk("rst_test_fetch", i_addr, m_pc);
        i_ready = 1'b1;
        i_data  = enc_i(35, 1, 5, 0);              // lw $5,0($1)
        @(negedge clk);
        i_ready = 1'b0;
        n = 0;
        while (!d_req && n < 10) begin @(negedge clk); n++; end
        chk("rst_test_d_req", d_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_d_req", d_req, 0);
        chk("abort_i_req", i_req, 0);
        chk("abort_retire", retire, 0);
        chk("abort_illegal", illegal, 0);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("abort_refetch_req", i_req, 1);
        chk("abort_refetch_pc", i_addr, 32'h0000_0000);
        exec_one(enc_i(43, 0, 5, 0), 0, 0);        // sw $5 -> 0

        // Randomized instruction stream
        for (int t = 0; t < 250; t++) begin
            exec_one(rand_instr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
